muacm_in_arb: RTL and testbench

Packet-aware round-robin arbiter that shares the single muacm IN byte pipe (USB → host) between N_SRC independent byte-stream sources. It sits between the user logic and the `in_*` port group of `muacm`. A granted source keeps the pipe until it ends a transfer with `last`, hits a burst cap, or goes idle. The arbiter issues `in_flush_now` itself when a source stops mid-transfer, so partial data is pushed to the host without per-source flush logic.

---
 rtl/muacm_in_arb.sv | 211 +++++++++++++++++++++
 tb/tb_muacm_in_arb.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muacm_in_arb.sv
// muacm_in_arb
// ------------
// Packet-aware round-robin arbiter that shares the single muacm IN byte pipe
// (device -> host) between N_SRC byte-stream sources. A granted source keeps
// the pipe until it ends a transfer with last, reaches MAX_BURST bytes, or
// stays silent for IDLE_TO cycles. If a source stops mid-transfer, the
// arbiter issues in_flush_now itself so the partial data reaches the host.
//
// Handshake: every byte channel uses valid/ready. A byte moves on a cycle
// where valid and ready are both high. Valid does not depend on ready.
// src_ready[i] is gnt[i] & in_ready, and is only high while BUSY.
//
// Ports:
//   clk, rst_n     - clock, synchronous active-low reset
//   src_data       - byte of source i on bits [8i+7:8i]
//   src_last       - per-source end-of-transfer marker
//   src_valid      - per-source byte available
//   src_ready      - per-source byte accepted this cycle
//   in_data/in_last/in_valid/in_ready - muacm IN pipe
//   in_flush_now   - one-cycle flush request (FLUSH state)
//   in_flush_time  - constant FLUSH_TIME
//   gnt            - one-hot registered grant, zero outside BUSY
//   dbg_state      - FSM state: 0 = IDLE, 1 = BUSY, 2 = FLUSH
module muacm_in_arb #(
    parameter int   N_SRC      = 2,
    parameter int   MAX_BURST  = 64,
    parameter int   IDLE_TO    = 16,
    parameter logic FLUSH_TIME = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [8*N_SRC-1:0] src_data,
    input  logic [N_SRC-1:0]   src_last,
    input  logic [N_SRC-1:0]   src_valid,
    output logic [N_SRC-1:0]   src_ready,
    output logic [7:0]         in_data,
    output logic               in_last,
    output logic               in_valid,
    input  logic               in_ready,
    output logic               in_flush_now,
    output logic               in_flush_time,
    output logic [N_SRC-1:0]   gnt,
    output logic [1:0]         dbg_state
);

    localparam int         PTR_W      = $clog2(N_SRC);
    localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);
    localparam logic [7:0] IDLE_LAST  = 8'(IDLE_TO - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t           state, state_d;
    logic [N_SRC-1:0] gnt_d;
    logic [PTR_W-1:0] rr_ptr, rr_ptr_d;
    logic [7:0]       burst_cnt, burst_cnt_d;
    logic [7:0]       idle_cnt, idle_cnt_d;
    logic             dirty, dirty_d;

    logic             busy;
    logic [7:0]       sel_data;
    logic             sel_last;
    logic             sel_valid;
    logic             xfer;
    logic [7:0]       idle_inc;

    logic             pick_found;
    logic [PTR_W-1:0] pick_idx;
    logic [PTR_W-1:0] cand;
    int               cand_i;

    // ------------------------------------------------------------------
    // Datapath: mux on the registered grant, gated by BUSY.
    // ------------------------------------------------------------------
    always_comb begin
        sel_data  = 8'h00;
        sel_last  = 1'b0;
        sel_valid = 1'b0;
        for (int i = 0; i < N_SRC; i++) begin
            if (gnt[i]) begin
                sel_data  = src_data[8*i +: 8];
                sel_last  = src_last[i];
                sel_valid = src_valid[i];
            end
        end
    end

    assign busy          = (state == ST_BUSY);
    assign in_data       = busy ? sel_data : 8'h00;
    assign in_last       = busy & sel_last;
    assign in_valid      = busy & sel_valid;
    assign src_ready     = busy ? (gnt & {N_SRC{in_ready}}) : '0;
    assign xfer          = in_valid & in_ready;
    assign in_flush_now  = (state == ST_FLUSH);
    assign in_flush_time = FLUSH_TIME;
    assign dbg_state     = state;
    assign idle_inc      = idle_cnt + 8'd1;

    // ------------------------------------------------------------------
    // Round-robin pick: first valid source after the last granted one.
    // ------------------------------------------------------------------
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = rr_ptr;
        cand_i     = 0;
        cand       = '0;
        for (int k = 1; k <= N_SRC; k++) begin
            cand_i = (int'(rr_ptr) + k) % N_SRC;
            cand   = PTR_W'(cand_i);
            if (!pick_found && src_valid[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic.
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state;
        gnt_d       = gnt;
        rr_ptr_d    = rr_ptr;
        burst_cnt_d = burst_cnt;
        idle_cnt_d  = idle_cnt;
        dirty_d     = dirty;

        unique case (state)
            ST_IDLE: begin
                if (pick_found) begin
                    gnt_d       = {{(N_SRC-1){1'b0}}, 1'b1} << pick_idx;
                    rr_ptr_d    = pick_idx;
                    burst_cnt_d = 8'd0;
                    idle_cnt_d  = 8'd0;
                    state_d     = ST_BUSY;
                end else if (dirty) begin
                    // Data left the pipe without last; push it out once the
                    // line has been quiet long enough.
                    idle_cnt_d = idle_inc;
                    if (idle_inc >= IDLE_LAST) begin
                        state_d = ST_FLUSH;
                    end
                end
            end

            ST_BUSY: begin
                if (sel_valid) begin
                    idle_cnt_d = 8'd0;
                end
                if (xfer) begin
                    if (sel_last) begin
                        // last wins over the burst cap, so nothing is pending.
                        dirty_d = 1'b0;
                        gnt_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        dirty_d     = 1'b1;
                        burst_cnt_d = burst_cnt + 8'd1;
                        if (burst_cnt == BURST_LAST) begin
                            gnt_d   = '0;
                            state_d = ST_IDLE;
                        end
                    end
                end else if (!sel_valid) begin
                    idle_cnt_d = idle_inc;
                    if (idle_inc >= IDLE_LAST) begin
                        gnt_d   = '0;
                        state_d = dirty ? ST_FLUSH : ST_IDLE;
                    end
                end
            end

            ST_FLUSH: begin
                gnt_d      = '0;
                dirty_d    = 1'b0;
                idle_cnt_d = 8'd0;
                state_d    = ST_IDLE;
            end

            default: begin
                gnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            gnt       <= '0;
            rr_ptr    <= PTR_W'(N_SRC - 1);
            burst_cnt <= 8'd0;
            idle_cnt  <= 8'd0;
            dirty     <= 1'b0;
        end else begin
            state     <= state_d;
            gnt       <= gnt_d;
            rr_ptr    <= rr_ptr_d;
            burst_cnt <= burst_cnt_d;
            idle_cnt  <= idle_cnt_d;
            dirty     <= dirty_d;
        end
    end

endmodule

// File: tb/tb_muacm_in_arb.sv
// Testbench for muacm_in_arb (N_SRC=2, MAX_BURST=4, IDLE_TO=16).
// Sources are fed from per-source byte queues; a reference model of the
// arbitration rules predicts every output each cycle, a scoreboard checks
// byte order per source, and directed scenarios pin timing with literals.
module tb_muacm_in_arb;

    localparam int   N_SRC      = 2;
    localparam int   MAX_BURST  = 4;
    localparam int   IDLE_TO    = 16;
    localparam logic FLUSH_TIME = 1'b1;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [8*N_SRC-1:0] src_data  = '0;
    logic [N_SRC-1:0]   src_last  = '0;
    logic [N_SRC-1:0]   src_valid = '0;
    logic [N_SRC-1:0]   src_ready;
    logic [7:0]         in_data;
    logic               in_last;
    logic               in_valid;
    logic               in_ready  = 1'b1;
    logic               in_flush_now;
    logic               in_flush_time;
    logic [N_SRC-1:0]   gnt;
    logic [1:0]         dbg_state;

    muacm_in_arb #(
        .N_SRC     (N_SRC),
        .MAX_BURST (MAX_BURST),
        .IDLE_TO   (IDLE_TO),
        .FLUSH_TIME(FLUSH_TIME)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .src_data     (src_data),
        .src_last     (src_last),
        .src_valid    (src_valid),
        .src_ready    (src_ready),
        .in_data      (in_data),
        .in_last      (in_last),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_flush_now (in_flush_now),
        .in_flush_time(in_flush_time),
        .gnt          (gnt),
        .dbg_state    (dbg_state)
    );

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // ---------------- stimulus state ----------------
    logic [8:0]       src_q [N_SRC][$];   // {last, data} still to be offered
    logic [8:0]       exp_q [N_SRC][$];   // {last, data} expected on the pipe
    logic             rdy_q [$];          // per-cycle in_ready overrides
    logic [N_SRC-1:0] acc = '0;           // source byte accepted at next edge

    // ---------------- observation logs ----------------
    int cyc = 0;
    int xfer_src_q [$];
    int xfer_cyc_q [$];
    int n_flush   = 0;
    int flush_cyc = 0;

    // ---------------- reference model ----------------
    // phase: 0 idle, 1 owner holds pipe, 2 flush pulse
    int m_phase   = 0;
    int m_owner   = -1;
    int m_prev    = N_SRC - 1;
    int m_nbytes  = 0;
    int m_quiet   = 0;
    bit m_pending = 1'b0;

    task automatic model_advance();
        if (!rst_n) begin
            m_phase = 0; m_owner = -1; m_prev = N_SRC - 1;
            m_nbytes = 0; m_quiet = 0; m_pending = 1'b0;
            return;
        end
        case (m_phase)
            0: begin
                if (src_valid != '0) begin
                    for (int k = 1; k <= N_SRC; k++) begin
                        int c;
                        c = (m_prev + k) % N_SRC;
                        if (m_owner < 0 && src_valid[c]) m_owner = c;
                    end
                    m_prev = m_owner; m_nbytes = 0; m_quiet = 0; m_phase = 1;
                end else if (m_pending) begin
                    m_quiet++;
                    if (m_quiet >= IDLE_TO - 1) m_phase = 2;
                end
            end
            1: begin
                if (src_valid[m_owner]) begin
                    m_quiet = 0;
                    if (in_ready) begin
                        if (src_last[m_owner]) begin
                            m_pending = 1'b0; m_phase = 0; m_owner = -1;
                        end else begin
                            m_pending = 1'b1;
                            m_nbytes++;
                            if (m_nbytes == MAX_BURST) begin
                                m_phase = 0; m_owner = -1;
                            end
                        end
                    end
                end else begin
                    m_quiet++;
                    if (m_quiet >= IDLE_TO - 1) begin
                        m_phase = m_pending ? 2 : 0;
                        m_owner = -1;
                    end
                end
            end
            default: begin
                m_phase = 0; m_pending = 1'b0; m_quiet = 0;
            end
        endcase
    endtask

    // ---------------- compare process (negedge) ----------------
    logic [N_SRC-1:0] e_gnt;
    logic [N_SRC-1:0] e_rdy;
    logic             e_valid;
    logic             e_last;
    logic [7:0]       e_data;
    logic [8:0]       sb_head;

    always @(negedge clk) begin
        e_gnt = '0; e_valid = 1'b0; e_last = 1'b0; e_data = 8'h00;
        if (m_phase == 1) begin
            e_gnt[m_owner] = 1'b1;
            e_valid        = src_valid[m_owner];
            e_last         = src_last[m_owner];
            e_data         = src_data[8*m_owner +: 8];
        end
        e_rdy = e_gnt & {N_SRC{in_ready}};
        check("gnt",        gnt,          e_gnt);
        check("src_ready",  src_ready,    e_rdy);
        check("in_valid",   in_valid,     e_valid);
        check("in_last",    in_last,      e_last);
        check("in_data",    in_data,      e_data);
        check("flush_now",  in_flush_now, (m_phase == 2));
        check("flush_time", in_flush_time, FLUSH_TIME);
        check("dbg_state",  dbg_state,    m_phase);

        if (in_valid && in_ready) begin
            xfer_src_q.push_back((m_phase == 1) ? m_owner : -1);
            xfer_cyc_q.push_back(cyc);
            if (m_phase == 1) begin
                check("sb_nonempty", (exp_q[m_owner].size() != 0), 1);
                if (exp_q[m_owner].size() != 0) begin
                    sb_head = exp_q[m_owner].pop_front();
                    check("sb_byte", {in_last, in_data}, sb_head);
                end
            end
        end
        if (in_flush_now) begin
            n_flush++;
            flush_cyc = cyc;
        end
        acc = src_valid & src_ready;
        model_advance();
        cyc++;
    end

    // ---------------- driver tasks ----------------
    task automatic drive_inputs();
        logic [8:0] head;
        for (int i = 0; i < N_SRC; i++) begin
            if (src_q[i].size() > 0) begin
                head                = src_q[i][0];
                src_valid[i]        = 1'b1;
                src_last[i]         = head[8];
                src_data[8*i +: 8]  = head[7:0];
            end else begin
                src_valid[i]        = 1'b0;
                src_last[i]         = 1'b0;
                src_data[8*i +: 8]  = 8'h00;
            end
        end
        if (rdy_q.size() > 0) in_ready = rdy_q.pop_front();
        else in_ready = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < N_SRC; i++)
            if (acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        drive_inputs();
    endtask

    task automatic ticks(int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic load(int s, logic [7:0] d, logic last);
        src_q[s].push_back({last, d});
        exp_q[s].push_back({last, d});
    endtask

    task automatic clear_logs();
        xfer_src_q.delete();
        xfer_cyc_q.delete();
        n_flush = 0;
    endtask

    task automatic clear_env();
        for (int i = 0; i < N_SRC; i++) begin
            src_q[i].delete();
            exp_q[i].delete();
        end
    endtask

    task automatic run_until_empty(string name, int budget);
        int n;
        n = 0;
        while ((src_q[0].size() + src_q[1].size()) > 0 && n < budget) begin
            tick();
            n++;
        end
        check(name, (n < budget), 1);
    endtask

    // ---------------- scenarios ----------------
    initial begin
        // reset
        ticks(2);
        check("rst_in_valid",  in_valid,      0);
        check("rst_gnt",       gnt,           0);
        check("rst_src_ready", src_ready,     0);
        check("rst_flush_now", in_flush_now,  0);
        check("rst_flush_time", in_flush_time, 1);
        rst_n = 1'b1;
        ticks(2);

        // 1: source 0 sends 0x11..0x15, last on 0x15 (cap of 4 splits it)
        clear_logs();
        for (int b = 0; b < 5; b++) load(0, 8'(8'h11 + b), (b == 4));
        drive_inputs();
        tick();
        check("t1_gnt",      gnt,      2'b01);
        check("t1_in_valid", in_valid, 1);
        check("t1_in_data",  in_data,  8'h11);
        run_until_empty("t1_drain", 40);
        ticks(20);
        check("t1_xfers", xfer_src_q.size(), 5);
        check("t1_span",  xfer_cyc_q[4] - xfer_cyc_q[0], 5);
        check("t1_flush", n_flush, 0);

        // 2: both sources loaded, no last, from reset priority
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        clear_env();
        clear_logs();
        for (int b = 0; b < 12; b++) begin
            load(0, 8'(8'h20 + b), 1'b0);
            load(1, 8'(8'h40 + b), 1'b0);
        end
        drive_inputs();
        run_until_empty("t2_drain", 80);
        check("t2_flush_busy", n_flush, 0);
        check("t2_xfers", xfer_src_q.size(), 24);
        for (int k = 0; k < 24; k++) check("t2_src_order", xfer_src_q[k], (k / 4) % 2);
        check("t2_span", xfer_cyc_q[23] - xfer_cyc_q[0], 28);
        ticks(20);
        check("t2_flush_cnt", n_flush, 1);
        check("t2_flush_lat", flush_cyc - xfer_cyc_q[23], 16);

        // 3: source 1 sends 3 bytes without last then goes silent
        clear_logs();
        for (int b = 0; b < 3; b++) load(1, 8'(8'h61 + b), 1'b0);
        drive_inputs();
        run_until_empty("t3_drain", 20);
        ticks(20);
        check("t3_xfers",     xfer_src_q.size(), 3);
        check("t3_flush_cnt", n_flush, 1);
        check("t3_flush_lat", flush_cyc - xfer_cyc_q[2], 16);
        check("t3_gnt_after", gnt, 0);
        check("t3_flush_off", in_flush_now, 0);

        // 4: in_ready 1,0,0,1 during a 4-byte transfer
        clear_logs();
        for (int b = 0; b < 4; b++) load(0, 8'(8'h71 + b), (b == 3));
        rdy_q = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        drive_inputs();
        run_until_empty("t4_drain", 20);
        ticks(20);
        check("t4_xfers", xfer_src_q.size(), 4);
        check("t4_gap",   xfer_cyc_q[1] - xfer_cyc_q[0], 3);
        check("t4_span",  xfer_cyc_q[3] - xfer_cyc_q[0], 5);
        check("t4_flush", n_flush, 0);

        // 5: last coincides with the burst cap
        clear_logs();
        for (int b = 0; b < 4; b++) load(0, 8'(8'h81 + b), (b == 3));
        drive_inputs();
        run_until_empty("t5_drain", 20);
        ticks(20);
        check("t5_xfers", xfer_src_q.size(), 4);
        check("t5_span",  xfer_cyc_q[3] - xfer_cyc_q[0], 3);
        check("t5_flush", n_flush, 0);
        check("t5_gnt",   gnt, 0);

        // 6: reset for one cycle in the middle of a burst
        clear_logs();
        for (int b = 0; b < 8; b++) load(0, 8'(8'h91 + b), 1'b0);
        drive_inputs();
        ticks(3);
        rst_n = 1'b0;
        tick();
        check("t6_in_valid",  in_valid,     0);
        check("t6_gnt",       gnt,          0);
        check("t6_flush_now", in_flush_now, 0);
        check("t6_src_ready", src_ready,    0);
        rst_n = 1'b1;
        clear_env();
        clear_logs();
        load(0, 8'hA1, 1'b1);
        load(1, 8'hB1, 1'b1);
        drive_inputs();
        tick();
        check("t6_first_gnt", gnt, 2'b01);
        run_until_empty("t6_drain", 20);
        ticks(20);
        check("t6_xfers",  xfer_src_q.size(), 2);
        check("t6_order0", xfer_src_q[0], 0);
        check("t6_order1", xfer_src_q[1], 1);
        check("t6_flush",  n_flush, 0);

        check("sb_drained", exp_q[0].size() + exp_q[1].size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
